// File: rtl/arb2_pkg.sv
// Shared defaults and output-register state encoding for the two-input round-robin arbiter.
// Latency: none (declarations only). Backpressure: not applicable.
package arb2_pkg;

    localparam int ARB2_DW = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb2_state_t;

endpackage

// File: rtl/mux2_bus.sv
// DW-wide 2:1 select feeding the arbiter output register.
// Latency: combinational. Backpressure: none, pure datapath.
module mux2_bus
#(
    parameter int DW = 8
)
(
    input  logic          sel,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    output logic [DW-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/arb2_rr.sv
// Two-requester round-robin arbiter into a one-entry registered output; ARB2_LOCK_EN adds packet lock via i_last0/i_last1.
// Latency: one cycle from grant to o_valid; sustains one beat per cycle when i_ready stays high.
// Backpressure: o_ready0/o_ready1 drop while the held beat is stalled by i_ready=0.
module arb2_rr
    import arb2_pkg::*;
#(
    parameter int DW = ARB2_DW
)
(
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_valid0,
    input  logic [DW-1:0] i_data0,
    input  logic          i_valid1,
    input  logic [DW-1:0] i_data1,
    output logic          o_ready0,
    output logic          o_ready1,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_sel,
    input  logic          i_ready
`ifdef ARB2_LOCK_EN
    ,
    input  logic          i_last0,
    input  logic          i_last1
`endif
);

    arb2_state_t   state_q;
    arb2_state_t   state_nxt;
    logic          prio_q;
    logic          load;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic [DW-1:0] mux_y;

`ifdef ARB2_LOCK_EN
    logic lock_q;
    logic owner_q;
    logic last_sel;

    // While locked only the owner may be granted, even if it is idle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (lock_q) begin
            grant0 = !owner_q && i_valid0;
            grant1 = owner_q && i_valid1;
        end else begin
            grant0 = i_valid0 && (!i_valid1 || !prio_q);
            grant1 = i_valid1 && (!i_valid0 || prio_q);
        end
    end

    assign last_sel = grant1 ? i_last1 : i_last0;
`else
    always_comb begin
        grant0 = i_valid0 && (!i_valid1 || !prio_q);
        grant1 = i_valid1 && (!i_valid0 || prio_q);
    end
`endif

    assign load     = !o_valid || i_ready;
    assign o_ready0 = load && grant0;
    assign o_ready1 = load && grant1;
    assign accept   = o_ready0 || o_ready1;

    mux2_bus #(.DW(DW)) u_mux (
        .sel (grant1),
        .in0 (i_data0),
        .in1 (i_data1),
        .y   (mux_y)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // A new grant refills the register in the same cycle the old beat leaves.
    always_comb begin
        state_nxt = state_q;
        if (accept) begin
            state_nxt = ST_FULL;
        end else if (load) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_comb begin
        o_valid = (state_q == ST_FULL);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_data <= '0;
            o_sel  <= 1'b0;
            prio_q <= 1'b0;
`ifdef ARB2_LOCK_EN
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
`endif
        end else if (accept) begin
            o_data <= mux_y;
            o_sel  <= grant1;
`ifdef ARB2_LOCK_EN
            if (last_sel) begin
                lock_q <= 1'b0;
                prio_q <= grant0;
            end else begin
                lock_q  <= 1'b1;
                owner_q <= grant1;
            end
`else
            prio_q <= grant0;
`endif
        end
    end

endmodule

// File: tb/tb_arb2_rr.sv
// Directed bench for arb2_rr: vector table plus short sequences for pulse width and packet lock.
module tb_arb2_rr;

    localparam int DW = 8;

    logic          clk;
    logic          rstn;
    logic          v0;
    logic          v1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          rdy;
    logic          o_ready0;
    logic          o_ready1;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_sel;
`ifdef ARB2_LOCK_EN
    logic          l0;
    logic          l1;
`endif

    int errs;
    int checks;

    arb2_rr #(.DW(DW)) dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_valid0 (v0),
        .i_data0  (d0),
        .i_valid1 (v1),
        .i_data1  (d1),
        .o_ready0 (o_ready0),
        .o_ready1 (o_ready1),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_sel    (o_sel),
        .i_ready  (rdy)
`ifdef ARB2_LOCK_EN
        ,
        .i_last0  (l0),
        .i_last1  (l1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rstn;
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          rdy;
        logic          e_ov;
        logic          e_os;
        logic [DW-1:0] e_od;
        logic          chkd;
        logic          e_r0;
        logic          e_r1;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic rs, input logic a0, input logic [DW-1:0] b0,
                                input logic a1, input logic [DW-1:0] b1, input logic rd,
                                input logic ov, input logic os, input logic [DW-1:0] od,
                                input logic cd, input logic r0, input logic r1);
        vec_t v;
        v.rstn = rs; v.v0 = a0; v.d0 = b0; v.v1 = a1; v.d1 = b1; v.rdy = rd;
        v.e_ov = ov; v.e_os = os; v.e_od = od; v.chkd = cd; v.e_r0 = r0; v.e_r1 = r1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

`ifdef ARB2_LOCK_EN
    task automatic lstep(input logic a0, input logic [DW-1:0] b0, input logic la0,
                         input logic a1, input logic [DW-1:0] b1, input logic la1,
                         input logic ov, input logic os, input logic [DW-1:0] od,
                         input logic cd, input logic r0, input logic r1, input string nm);
        @(negedge clk);
        v0 = a0; d0 = b0; l0 = la0; v1 = a1; d1 = b1; l1 = la1; rdy = 1'b1;
        #1;
        chk({nm, "_ov"}, 32'(o_valid), 32'(ov));
        if (cd) begin
            chk({nm, "_os"}, 32'(o_sel), 32'(os));
            chk({nm, "_od"}, 32'(o_data), 32'(od));
        end
        chk({nm, "_r0"}, 32'(o_ready0), 32'(r0));
        chk({nm, "_r1"}, 32'(o_ready1), 32'(r1));
    endtask
`endif

    initial begin
        int cnt;
        int first;
        errs   = 0;
        checks = 0;
        rstn = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; rdy = 1'b0;
`ifdef ARB2_LOCK_EN
        l0 = 1'b1; l1 = 1'b1;
`endif

        //             rs a0 d0     a1 d1     rd  ov os od     cd r0 r1
        tbl[0]  = mk(1, 1, 8'hA5, 0, 8'h00, 1,  0, 0, 8'h00, 1, 1, 0);
        tbl[1]  = mk(1, 0, 8'h00, 0, 8'h00, 1,  1, 0, 8'hA5, 1, 0, 0);
        tbl[2]  = mk(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);
        tbl[3]  = mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);
        tbl[4]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  0, 0, 8'h00, 1, 1, 0);
        tbl[5]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 0, 8'h11, 1, 0, 1);
        tbl[6]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 1, 8'h22, 1, 1, 0);
        tbl[7]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 0, 8'h11, 1, 0, 1);
        tbl[8]  = mk(1, 1, 8'h11, 1, 8'h22, 0,  1, 1, 8'h22, 1, 0, 0);
        tbl[9]  = mk(1, 1, 8'h11, 1, 8'h22, 0,  1, 1, 8'h22, 1, 0, 0);
        tbl[10] = mk(1, 1, 8'h11, 1, 8'h22, 0,  1, 1, 8'h22, 1, 0, 0);
        tbl[11] = mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 1, 8'h22, 1, 1, 0);
        tbl[12] = mk(0, 1, 8'h11, 1, 8'h22, 1,  1, 0, 8'h11, 1, 0, 1);
        tbl[13] = mk(1, 1, 8'h11, 1, 8'h22, 1,  0, 0, 8'h00, 1, 1, 0);
        tbl[14] = mk(1, 0, 8'h00, 0, 8'h00, 1,  1, 0, 8'h11, 1, 0, 0);
        tbl[15] = mk(1, 0, 8'h00, 1, 8'h5C, 0,  0, 0, 8'h00, 0, 0, 1);
        tbl[16] = mk(1, 1, 8'h77, 0, 8'h00, 0,  1, 1, 8'h5C, 1, 0, 0);
        tbl[17] = mk(1, 1, 8'h77, 0, 8'h00, 1,  1, 1, 8'h5C, 1, 1, 0);
        tbl[18] = mk(1, 0, 8'h00, 0, 8'h00, 0,  1, 0, 8'h77, 1, 0, 0);
        tbl[19] = mk(1, 0, 8'h00, 0, 8'h00, 1,  1, 0, 8'h77, 1, 0, 0);
        tbl[20] = mk(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rstn = tbl[i].rstn; v0 = tbl[i].v0; d0 = tbl[i].d0;
            v1 = tbl[i].v1; d1 = tbl[i].d1; rdy = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d_ov", i), 32'(o_valid), 32'(tbl[i].e_ov));
            if (tbl[i].chkd) begin
                chk($sformatf("row%0d_os", i), 32'(o_sel), 32'(tbl[i].e_os));
                chk($sformatf("row%0d_od", i), 32'(o_data), 32'(tbl[i].e_od));
            end
            chk($sformatf("row%0d_r0", i), 32'(o_ready0), 32'(tbl[i].e_r0));
            chk($sformatf("row%0d_r1", i), 32'(o_ready1), 32'(tbl[i].e_r1));
        end

        // Single beat followed by idle: o_valid must pulse for exactly one cycle.
        @(negedge clk);
        v0 = 1'b1; d0 = 8'h3C; v1 = 1'b0; rdy = 1'b1;
        #1;
        chk("pulse_r0", 32'(o_ready0), 32'd1);
        @(negedge clk);
        v0 = 1'b0;
        cnt   = 0;
        first = -1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (o_valid) begin
                cnt++;
                if (first < 0) first = k;
                chk("pulse_od", 32'(o_data), 32'h3C);
            end
            @(negedge clk);
        end
        chk("pulse_count", 32'(cnt), 32'd1);
        chk("pulse_pos", 32'(first), 32'd0);

`ifdef ARB2_LOCK_EN
        @(negedge clk);
        rstn = 1'b0; v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        //     a0 d0     l0 a1 d1     l1 ov os od     cd r0 r1
        lstep(1, 8'h01, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0, "lk0");
        lstep(1, 8'h02, 1, 1, 8'hB1, 0, 1, 0, 8'h01, 1, 0, 1, "lk1");
        lstep(1, 8'h02, 1, 1, 8'hB2, 0, 1, 1, 8'hB1, 1, 0, 1, "lk2");
        lstep(1, 8'h02, 1, 1, 8'hB3, 1, 1, 1, 8'hB2, 1, 0, 1, "lk3");
        lstep(1, 8'h02, 1, 0, 8'h00, 0, 1, 1, 8'hB3, 1, 1, 0, "lk4");
        lstep(0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h02, 1, 0, 0, "lk5");
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
